smg_score_scan: RTL

Parametrised successor to the two-digit score display in the snake game. It keeps a DIGITS-wide BCD score that increments on each rising edge of `Body_add_sig` and clears while the game is in END. It also keeps a sticky high score. Either value is driven onto a multiplexed, active-low seven-segment display with leading-zero blanking. The block sits between the game FSM (`Game_status`, `Body_add_sig`) and the board's digit/segment pins.

---
 rtl/smg_pkg.sv | 38 +++
 rtl/smg_bcd_counter.sv | 51 +++++
 rtl/smg_score_scan.sv | 118 +++++++++++
 3 files changed

// File: rtl/smg_pkg.sv
// Shared constants for the score display: game status encodings,
// active-low seven-segment patterns and the BCD-to-segment decoder.
package smg_pkg;

    localparam logic [2:0] ST_START = 3'b001;
    localparam logic [2:0] ST_PLAY  = 3'b010;
    localparam logic [2:0] ST_END   = 3'b100;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Decimal point (bit 7) stays off in every pattern; non-BCD nibbles go blank.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/smg_bcd_counter.sv
// Multi-digit BCD counter with synchronous clear and single-step increment.
// Ports: Clk_50mhz, Rst (sync, active-high), clr (clear, beats inc),
//        inc (add one), bcd (packed digits, digit i at [4i+3:4i]).
module smg_bcd_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  Clk_50mhz,
    input  logic                  Rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] bcd_inc;
    logic         carry;
    logic         all_nines;

    // Ripple carry: a digit advances only while every lower digit is 9.
    always_comb begin
        bcd_inc   = bcd;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            bcd <= '0;
        end else if (clr) begin
            bcd <= '0;
        end else if (inc && !(SATURATE && all_nines)) begin
            bcd <= bcd_inc;
        end
    end

endmodule

// File: rtl/smg_score_scan.sv
// Snake-game score keeper and multiplexed seven-segment driver.
// Ports: Clk_50mhz, Rst (sync, active-high), Body_add_sig (level, each rise
//        scores), Game_status (one-hot START/PLAY/END), Show_high (display
//        select), Score_bcd / High_bcd (packed BCD), Smg_duan (active-low
//        segments), Smg_we (one-cold digit enables).
module smg_score_scan
    import smg_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned SCAN_CYCLES   = 50000,
    parameter bit          SATURATE      = 1'b0,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  Clk_50mhz,
    input  logic                  Rst,
    input  logic                  Body_add_sig,
    input  logic [2:0]            Game_status,
    input  logic                  Show_high,
    output logic [4*DIGITS-1:0]   Score_bcd,
    output logic [4*DIGITS-1:0]   High_bcd,
    output logic [7:0]            Smg_duan,
    output logic [DIGITS-1:0]     Smg_we
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(SCAN_CYCLES);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    logic             add_d;
    logic             add_q;
    logic             add_pulse;
    logic             is_end;
    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] dig_idx;
    logic [W-1:0]     disp;
    logic [3:0]       nibble;
    logic             zero_above;
    logic             blank;
    logic [7:0]       seg_next;
    logic [DIGITS-1:0] we_next;

    assign is_end    = (Game_status == ST_END);
    assign add_pulse = Body_add_sig & ~add_d;

    // Edge detect; the pulse is registered once and dropped if it rose during END.
    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            add_d <= 1'b0;
            add_q <= 1'b0;
        end else begin
            add_d <= Body_add_sig;
            add_q <= add_pulse & ~is_end;
        end
    end

    smg_bcd_counter #(
        .DIGITS   (DIGITS),
        .SATURATE (SATURATE)
    ) u_score (
        .Clk_50mhz (Clk_50mhz),
        .Rst       (Rst),
        .clr       (is_end),
        .inc       (add_q),
        .bcd       (Score_bcd)
    );

    // Sticky record; packed BCD compares in numeric order.
    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            High_bcd <= '0;
        end else if (Score_bcd > High_bcd) begin
            High_bcd <= Score_bcd;
        end
    end

    // Digit scan timer.
    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    assign disp = Show_high ? High_bcd : Score_bcd;

    // Walk from the top digit down so zero_above covers digits i..DIGITS-1.
    always_comb begin
        nibble     = 4'd0;
        blank      = 1'b0;
        zero_above = 1'b1;
        we_next    = '1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
            if (dig_idx == IDX_W'(i)) begin
                nibble     = disp[4*i +: 4];
                blank      = BLANK_LEADING && (i != 0) && zero_above;
                we_next[i] = 1'b0;
            end
        end
        seg_next = blank ? SEG_BLANK : bcd_to_seg(nibble);
    end

    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            Smg_we   <= '1;
            Smg_duan <= SEG_BLANK;
        end else begin
            Smg_we   <= we_next;
            Smg_duan <= seg_next;
        end
    end

endmodule
